// File: rtl/evt_pkg.sv
// Shared constants, width helper and record type for the event catcher.
package evt_pkg;

   localparam int DEF_NUM_EV = 4;
   localparam int DEF_CNT_W  = 4;
   localparam int DEF_TS_W   = 16;

   // Index width for n lines. A single-bit id is kept even when n is 1.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_ID_W = id_width(DEF_NUM_EV);

   // One emitted record at the default widths.
   typedef struct packed {
      logic [DEF_ID_W-1:0]  id;
      logic [DEF_TS_W-1:0]  ts;
      logic [DEF_CNT_W-1:0] count;
   } evt_rec_t;

endpackage

// File: rtl/evt_rr_arbiter.sv
// Round-robin arbiter. The search starts one index past the last grant and
// wraps around. The pointer moves only when the grant is consumed.
module evt_rr_arbiter
   import evt_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = id_width(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] r_last;
   logic             w_hi_found;
   logic             w_lo_found;
   logic [IDX_W-1:0] w_hi_idx;
   logic [IDX_W-1:0] w_lo_idx;

   // Find the lowest requester above the last grant, and the lowest requester
   // at or below it. The upper group has priority, which gives the wrap order.
   always_comb begin
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (req[j]) begin
            if (IDX_W'(j) > r_last) begin
               w_hi_found = 1'b1;
               w_hi_idx   = IDX_W'(j);
            end else begin
               w_lo_found = 1'b1;
               w_lo_idx   = IDX_W'(j);
            end
         end
      end
   end

   assign grant_valid = w_hi_found | w_lo_found;
   assign grant_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

   // Last-grant pointer. It resets to N-1 so that index 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= IDX_W'(N - 1);
      end else if (advance && grant_valid) begin
         r_last <= grant_idx;
      end
   end

endmodule

// File: rtl/event_catcher.sv
// Event catcher. It catches single-cycle trigger pulses on each event line and
// coalesces repeated triggers into a saturating per-event counter. Each
// counter stores the time of the first trigger in its batch. Batches are
// emitted one at a time, in round-robin order, as records on a valid/ready
// stream.
//
// Output stream: the record (out_id, out_ts, out_count) is transferred on a
// rising edge where out_valid and out_ready are both high. While out_valid is
// high and out_ready is low, every out_* signal holds stable. The output
// register reloads on the same edge as a transfer, so back-to-back records
// leave no bubble.
module event_catcher
   import evt_pkg::*;
#(
   parameter  int NUM_EV = DEF_NUM_EV,
   parameter  int CNT_W  = DEF_CNT_W,
   parameter  int TS_W   = DEF_TS_W,
   localparam int ID_W   = id_width(NUM_EV)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_EV-1:0] ev_trig,
   input  logic [NUM_EV-1:0] ovf_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ID_W-1:0]   out_id,
   output logic [TS_W-1:0]   out_ts,
   output logic [CNT_W-1:0]  out_count,
   output logic [NUM_EV-1:0] pending,
   output logic [NUM_EV-1:0] ovf,
   output logic [TS_W-1:0]   time_now
);

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [TS_W-1:0]  ts;
      logic [CNT_W-1:0] count;
   } rec_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [TS_W-1:0]  r_time;
   rec_t             r_out;
   logic             r_out_valid;

   logic [CNT_W-1:0] w_cnt      [NUM_EV];
   logic [TS_W-1:0]  w_first_ts [NUM_EV];
   logic [NUM_EV-1:0] w_ovf;
   logic [NUM_EV-1:0] w_req;

   logic             w_load;
   logic             w_grant;
   logic             w_grant_valid;
   logic [ID_W-1:0]  w_grant_idx;
   logic [CNT_W-1:0] w_sel_cnt;
   logic [TS_W-1:0]  w_sel_ts;

   // The output register may reload when it is empty or is being drained now.
   assign w_load  = !r_out_valid || out_ready;
   assign w_grant = w_load && w_grant_valid;

   evt_rr_arbiter #(
      .N (NUM_EV)
   ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (w_req),
      .advance     (w_grant),
      .grant_valid (w_grant_valid),
      .grant_idx   (w_grant_idx)
   );

   // Free-running timestamp counter. It wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_time <= '0;
      end else begin
         r_time <= r_time + TS_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_EV; i++) begin : g_ev
      logic [CNT_W-1:0] r_cnt;
      logic [TS_W-1:0]  r_first_ts;
      logic             r_ovf;
      logic             w_hit;

      assign w_hit = w_grant && (w_grant_idx == ID_W'(i));

      // Per-event batch counter. A grant empties the counter. A trigger on
      // the same edge starts a new batch, so that trigger is kept.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt      <= '0;
            r_first_ts <= '0;
         end else if (w_hit) begin
            if (ev_trig[i]) begin
               r_cnt      <= CNT_W'(1);
               r_first_ts <= r_time;
            end else begin
               r_cnt      <= '0;
            end
         end else if (ev_trig[i]) begin
            if (r_cnt == '0) begin
               r_cnt      <= CNT_W'(1);
               r_first_ts <= r_time;
            end else if (r_cnt != CNT_MAX) begin
               r_cnt      <= r_cnt + CNT_W'(1);
            end
         end
      end

      // Sticky overflow flag. A trigger into a full, ungranted counter sets
      // the flag, and a set beats a clear on the same edge.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_ovf <= 1'b0;
         end else if (ev_trig[i] && !w_hit && (r_cnt == CNT_MAX)) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr[i]) begin
            r_ovf <= 1'b0;
         end
      end

      assign w_cnt[i]      = r_cnt;
      assign w_first_ts[i] = r_first_ts;
      assign w_ovf[i]      = r_ovf;
      assign w_req[i]      = (r_cnt != '0);
   end

   // Select the granted event's batch so it can be loaded into the output register.
   always_comb begin
      w_sel_cnt = '0;
      w_sel_ts  = '0;
      for (int i = 0; i < NUM_EV; i++) begin
         if (w_grant_idx == ID_W'(i)) begin
            w_sel_cnt = w_cnt[i];
            w_sel_ts  = w_first_ts[i];
         end
      end
   end

   // Output record register. When nothing is pending it only drops valid and
   // leaves the stale fields in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         if (w_grant_valid) begin
            r_out.id    <= w_grant_idx;
            r_out.ts    <= w_sel_ts;
            r_out.count <= w_sel_cnt;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_id    = r_out.id;
   assign out_ts    = r_out.ts;
   assign out_count = r_out.count;
   assign pending   = w_req;
   assign ovf       = w_ovf;
   assign time_now  = r_time;

endmodule

// File: tb/tb_event_catcher.sv
// Bench for event_catcher: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of batches, timestamps and the
// round-robin order.
module tb_event_catcher;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int TW = 16;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  ev_trig = '0;
  logic [N-1:0]  ovf_clr = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [1:0]    out_id;
  logic [TW-1:0] out_ts;
  logic [CW-1:0] out_count;
  logic [N-1:0]  pending;
  logic [N-1:0]  ovf;
  logic [TW-1:0] time_now;

  event_catcher u_dut (
    .clk(clk), .rst_n(rst_n), .ev_trig(ev_trig), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_ts(out_ts), .out_count(out_count), .pending(pending), .ovf(ovf),
    .time_now(time_now)
  );

  // Narrow-timestamp instance, left idle, used to watch time_now wrap.
  logic         s_valid;
  logic [1:0]   s_id;
  logic [3:0]   s_ts;
  logic [CW-1:0] s_count;
  logic [N-1:0] s_pending;
  logic [N-1:0] s_ovf;
  logic [3:0]   s_time;

  event_catcher #(.TS_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .ev_trig(4'b0000), .ovf_clr(4'b0000),
    .out_valid(s_valid), .out_ready(1'b1), .out_id(s_id),
    .out_ts(s_ts), .out_count(s_count), .pending(s_pending), .ovf(s_ovf),
    .time_now(s_time)
  );

  // ---------------- scoreboard / model ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  int       m_cnt [N];
  int       m_ts  [N];
  logic [N-1:0] m_ovf;
  int       m_now;
  int       m_ptr;
  logic     m_valid;
  int       m_id, m_rts, m_rcnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_rec(input int id, input int ts, input int cnt);
    return 32'((id << 20) | (ts << 4) | cnt);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_ts[i]  = 0;
    end
    m_ovf = '0; m_now = 0; m_ptr = 0; m_valid = 1'b0;
    m_id = 0; m_rts = 0; m_rcnt = 0;
    exp_q.delete();
  endtask

  function automatic logic [N-1:0] m_pending();
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  // ---------------- driver ----------------
  // One clock. It drives the inputs, advances the model, checks any handshake
  // at this edge, and then compares the full visible state after the edge.
  task automatic cycle(input logic [N-1:0] trig, input logic [N-1:0] clr, input logic rdy);
    bit found;
    ev_trig = trig; ovf_clr = clr; out_ready = rdy;
    #1;
    if (out_valid && rdy) begin
      check_val("hs_queue", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0)
        check_val("hs_rec", pack_rec(int'(out_id), int'(out_ts), int'(out_count)), exp_q.pop_front());
    end
    // Load stage: the output may take a new batch when it is empty or is being taken now.
    if (!m_valid || rdy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && m_cnt[j] != 0) begin
          found = 1;
          m_id = j; m_rts = m_ts[j]; m_rcnt = m_cnt[j];
          m_cnt[j] = 0;
          m_ptr = (j + 1) % N;
          exp_q.push_back(pack_rec(m_id, m_rts, m_rcnt));
        end
      end
      m_valid = found;
    end
    // Trigger capture on the (possibly just emptied) counters.
    for (int i = 0; i < N; i++) begin
      bit set;
      set = 0;
      if (trig[i]) begin
        if (m_cnt[i] == 0) begin
          m_cnt[i] = 1; m_ts[i] = m_now;
        end else if (m_cnt[i] < CMAX) begin
          m_cnt[i]++;
        end else begin
          set = 1;
        end
      end
      if (set) m_ovf[i] = 1'b1;
      else if (clr[i]) m_ovf[i] = 1'b0;
    end
    m_now = (m_now + 1) % (1 << TW);
    @(posedge clk);
    #1;
    check_val("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check_val("out_id", 32'(out_id), 32'(m_id));
      check_val("out_ts", 32'(out_ts), 32'(m_rts));
      check_val("out_count", 32'(out_count), 32'(m_rcnt));
    end
    check_val("pending", 32'(pending), 32'(m_pending()));
    check_val("ovf", 32'(ovf), 32'(m_ovf));
    check_val("time_now", 32'(time_now), 32'(m_now));
    check_val("small_time", 32'(s_time), 32'(m_now % 16));
    check_val("small_idle", 32'({s_valid, s_id, s_ts, s_count, s_pending, s_ovf}), 32'd0);
  endtask

  task automatic idle_until(input int t, input logic rdy);
    while (m_now < t) cycle('0, '0, rdy);
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, 32'({out_valid, out_id, out_ts, out_count, pending, ovf, time_now}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // Single trigger of event 0 at time 5.
    idle_until(5, 1'b1);
    cycle(4'b0001, '0, 1'b1);
    cycle('0, '0, 1'b1);
    check_val("t1_rec", pack_rec(int'(out_id), int'(out_ts), int'(out_count)), pack_rec(0, 5, 1));
    cycle('0, '0, 1'b1);
    check_val("t1_drop", 32'({out_valid, pending}), 32'd0);

    // Occupy the output with event 0, then coalesce three triggers of event 2.
    idle_until(8, 1'b1);
    cycle(4'b0001, '0, 1'b0);
    cycle('0, '0, 1'b0);
    cycle(4'b0100, '0, 1'b0);
    cycle('0, '0, 1'b0);
    cycle(4'b0100, '0, 1'b0);
    cycle('0, '0, 1'b0);
    cycle(4'b0100, '0, 1'b0);
    repeat (3) cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b1);
    check_val("t2_rec", pack_rec(int'(out_id), int'(out_ts), int'(out_count)), pack_rec(2, 10, 3));
    cycle('0, '0, 1'b1);

    // All four events in one cycle, twice, so the pointer has to wrap.
    idle_until(20, 1'b1);
    cycle(4'b1111, '0, 1'b1);
    repeat (4) cycle('0, '0, 1'b1);
    cycle(4'b1111, '0, 1'b1);
    repeat (5) cycle('0, '0, 1'b1);

    // Saturate event 1 behind a stalled record, then clear overflow, then
    // clear it on the same edge as a saturating trigger.
    cycle(4'b0001, '0, 1'b0);
    repeat (20) cycle(4'b0010, '0, 1'b0);
    check_val("t4_ovf_set", 32'(ovf[1]), 32'd1);
    cycle('0, 4'b0010, 1'b0);
    check_val("t4_ovf_clr", 32'(ovf[1]), 32'd0);
    cycle(4'b0010, 4'b0010, 1'b0);
    check_val("t4_ovf_win", 32'(ovf[1]), 32'd1);
    cycle('0, 4'b0010, 1'b1);
    check_val("t4_sat_rec", 32'(out_count), 32'd15);
    repeat (4) cycle('0, '0, 1'b1);

    // Event 3 triggers again on the edge where its first batch is loaded.
    idle_until(100, 1'b1);
    cycle(4'b1000, '0, 1'b1);
    cycle(4'b1000, '0, 1'b1);
    check_val("t5_old", pack_rec(int'(out_id), int'(out_ts), int'(out_count)), pack_rec(3, 100, 1));
    cycle('0, '0, 1'b1);
    check_val("t5_new", pack_rec(int'(out_id), int'(out_ts), int'(out_count)), pack_rec(3, 101, 1));
    repeat (2) cycle('0, '0, 1'b1);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [N-1:0] t, c;
      for (int i = 0; i < N; i++) begin
        t[i] = ($urandom_range(0, 3) == 0);
        c[i] = ($urandom_range(0, 15) == 0);
      end
      cycle(t, c, ($urandom_range(0, 3) != 0));
    end

    // Reset asserted mid-cycle while a record is held and two events are pending.
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b1);
    repeat (4) cycle('0, '0, 1'b1);
    cycle(4'b0001, '0, 1'b0);
    cycle(4'b0110, '0, 1'b0);
    check_val("rst_pre", 32'({out_valid, pending}), 32'({1'b1, 4'b0110}));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check_val("small_reset", 32'(s_time), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic again after reset; the narrow counter wraps many times.
    for (int n = 0; n < 300; n++) begin
      logic [N-1:0] t;
      for (int i = 0; i < N; i++) t[i] = ($urandom_range(0, 4) == 0);
      cycle(t, '0, ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
